// File: rtl/pulse_gen_multi.sv
`timescale 1ns/1ps
// pulse_gen_multi: multi-channel edge-to-pulse generator.
// Each channel turns a qualifying edge on enable[i] into a registered
// trigger[i] pulse of PULSE_LEN cycles, followed by an optional HOLDOFF
// window. Edges arriving while busy either restart the pulse (RETRIGGER=1)
// or set a sticky missed[i] flag (RETRIGGER=0).
// Optional build macro PULSE_SYNC_EN: inserts a 2-flop synchroniser on each
// enable bit so enable may be asynchronous to clk (adds 2 cycles latency).
module pulse_gen_multi #(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 1,
    parameter int EDGE_MODE = 0,   // 0 rising, 1 falling, 2 both
    parameter int HOLDOFF   = 0,
    parameter int RETRIGGER = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] clr_missed,
    output logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] missed
);

    localparam int MAX_LEN = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
    localparam int CW      = ($clog2(MAX_LEN + 1) < 1) ? 1 : $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [CHANNELS-1:0] en_s;      // enable as seen by edge detect
    logic [CHANNELS-1:0] prev;      // previous sample of en_s
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] edge_hit;

    // Previous-sample register for edge detection; resets to 0 so a level
    // held high through reset release yields exactly one rising edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= en_s;
        end
    end

`ifdef PULSE_SYNC_EN
    logic [CHANNELS-1:0] sync_q1;
    logic [CHANNELS-1:0] sync_q2;

    // Two-flop synchroniser bringing asynchronous enable into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= enable;
            sync_q2 <= sync_q1;
        end
    end

    assign en_s = sync_q2;
`else
    assign en_s = enable;
`endif

    assign rise     = en_s & ~prev;
    assign fall     = ~en_s & prev;
    assign edge_hit = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          trig_q;
        logic          busy_q;
        logic          miss_q;

        // Per-channel IDLE/PULSE/HOLD sequencer with registered outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                trig_q <= 1'b0;
                busy_q <= 1'b0;
                miss_q <= 1'b0;
            end else begin
                // A dropped edge later in this block overrides the clear.
                if (clr_missed[i]) begin
                    miss_q <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        if (edge_hit[i]) begin
                            state  <= PULSE;
                            cnt    <= PULSE_LOAD;
                            trig_q <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    PULSE, HOLD: begin
                        if (edge_hit[i] && (RETRIGGER != 0)) begin
                            state  <= PULSE;
                            cnt    <= PULSE_LOAD;
                            trig_q <= 1'b1;
                            busy_q <= 1'b1;
                        end else begin
                            if (edge_hit[i]) begin
                                miss_q <= 1'b1;
                            end
                            if (cnt != '0) begin
                                cnt <= cnt - CW'(1);
                            end else if ((state == PULSE) && (HOLDOFF != 0)) begin
                                state  <= HOLD;
                                cnt    <= HOLD_LOAD;
                                trig_q <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                trig_q <= 1'b0;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        trig_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign trigger[i] = trig_q;
        assign busy[i]    = busy_q;
        assign missed[i]  = miss_q;
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
`timescale 1ns/1ps
// tb_pulse_gen_multi: four differently configured instances share one set
// of enable/clr_missed stimulus. A timeline reference model predicts each
// channel's outputs per cycle; predictions are queued and a monitor process
// compares them against the DUTs between clock edges.
module tb_pulse_gen_multi;

    localparam int N_DUT = 4;
    localparam int CH    = 4;
    localparam int PL_A [N_DUT] = '{1, 4, 4, 8};
    localparam int EM_A [N_DUT] = '{0, 0, 2, 1};
    localparam int HO_A [N_DUT] = '{0, 3, 0, 2};
    localparam int RT_A [N_DUT] = '{0, 0, 1, 0};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] enable = '0;
    logic [CH-1:0] clr_missed = '0;
    logic [CH-1:0] trig_w [N_DUT];
    logic [CH-1:0] busy_w [N_DUT];
    logic [CH-1:0] miss_w [N_DUT];

    for (genvar d = 0; d < N_DUT; d++) begin : g_dut
        pulse_gen_multi #(
            .CHANNELS (CH),
            .PULSE_LEN(PL_A[d]),
            .EDGE_MODE(EM_A[d]),
            .HOLDOFF  (HO_A[d]),
            .RETRIGGER(RT_A[d])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .clr_missed(clr_missed),
            .trigger   (trig_w[d]),
            .busy      (busy_w[d]),
            .missed    (miss_w[d])
        );
    end

    always #5 clk = ~clk;

    typedef struct packed {
        int                         cyc;
        logic [N_DUT-1:0][CH-1:0]   trig;
        logic [N_DUT-1:0][CH-1:0]   busy;
        logic [N_DUT-1:0][CH-1:0]   miss;
    } exp_t;

    exp_t exp_q [$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: each channel is described by the last cycle its
    // pulse and its busy window cover, plus a sticky missed bit.
    int            t_cyc = 0;
    int            trig_end [N_DUT][CH];
    int            busy_end [N_DUT][CH];
    bit            miss_m   [N_DUT][CH];
    logic [CH-1:0] prev_m;
    logic [CH-1:0] pipe1;
    logic [CH-1:0] pipe2;

    task automatic check(input string name, input int d, input int cyc,
                         input logic [CH-1:0] got, input logic [CH-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s u%0d cyc %0d: got %b want %b", name, d, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < N_DUT; d++) begin
            for (int c = 0; c < CH; c++) begin
                trig_end[d][c] = -10;
                busy_end[d][c] = -10;
                miss_m[d][c]   = 1'b0;
            end
        end
        prev_m = '0;
        pipe1  = '0;
        pipe2  = '0;
    endtask

    task automatic model_step(input logic [CH-1:0] en, input logic [CH-1:0] clr,
                              output exp_t e);
        logic [CH-1:0] eff;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] hit;
        bit            dropped;
        t_cyc++;
`ifdef PULSE_SYNC_EN
        eff   = pipe2;
        pipe2 = pipe1;
        pipe1 = en;
`else
        eff = en;
`endif
        rise   = eff & ~prev_m;
        fall   = ~eff & prev_m;
        prev_m = eff;
        e      = '0;
        e.cyc  = t_cyc;
        for (int d = 0; d < N_DUT; d++) begin
            hit = (EM_A[d] == 0) ? rise : (EM_A[d] == 1) ? fall : (rise | fall);
            for (int c = 0; c < CH; c++) begin
                dropped = 1'b0;
                if (hit[c]) begin
                    // Channel is free only if busy was already low before this edge.
                    if ((t_cyc >= busy_end[d][c] + 2) || (RT_A[d] != 0)) begin
                        trig_end[d][c] = t_cyc + PL_A[d] - 1;
                        busy_end[d][c] = t_cyc + PL_A[d] + HO_A[d] - 1;
                    end else begin
                        miss_m[d][c] = 1'b1;
                        dropped      = 1'b1;
                    end
                end
                if (clr[c] && !dropped) begin
                    miss_m[d][c] = 1'b0;
                end
                e.trig[d][c] = (t_cyc <= trig_end[d][c]);
                e.busy[d][c] = (t_cyc <= busy_end[d][c]);
                e.miss[d][c] = miss_m[d][c];
            end
        end
    endtask

    // One clock of stimulus: drive at the falling edge, queue the prediction
    // for the following rising edge; optionally release reset in the same slot.
    task automatic step(input logic [CH-1:0] en, input logic [CH-1:0] clr,
                        input bit release_rst);
        exp_t e;
        @(negedge clk);
        if (release_rst) begin
            rst = 1'b0;
        end
        enable     = en;
        clr_missed = clr;
        model_step(en, clr, e);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_zero();
        for (int d = 0; d < N_DUT; d++) begin
            check("rst trigger", d, t_cyc, trig_w[d], '0);
            check("rst busy",    d, t_cyc, busy_w[d], '0);
            check("rst missed",  d, t_cyc, miss_w[d], '0);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic assert_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_zero();
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic random_run(input int n);
        logic [CH-1:0] en;
        logic [CH-1:0] clr;
        en = enable;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 3) == 0) en[c] = ~en[c];
                clr[c] = ($urandom_range(0, 15) == 0);
            end
            step(en, clr, 1'b0);
        end
    endtask

    // Monitor: compare the queued prediction just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < N_DUT; d++) begin
                    check("trigger", d, e.cyc, trig_w[d], e.trig[d]);
                    check("busy",    d, e.cyc, busy_w[d], e.busy[d]);
                    check("missed",  d, e.cyc, miss_w[d], e.miss[d]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_zero();
        repeat (3) @(posedge clk);

        // Level held high: one pulse, none while it stays high
        step(4'b0000, 4'b0000, 1'b1);
        repeat (3)  step(4'b0000, 4'b0000, 1'b0);
        repeat (10) step(4'b1111, 4'b0000, 1'b0);
        repeat (3)  step(4'b0000, 4'b0000, 1'b0);
        repeat (2)  step(4'b1111, 4'b0000, 1'b0);

        // Dropped edges, then set and clear of missed in the same cycle
        repeat (12) step(4'b0000, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b1111, 4'b1111, 1'b0);
        step(4'b1111, 4'b1111, 1'b0);
        repeat (4)  step(4'b1111, 4'b0000, 1'b0);

        // Per-channel patterns
        step(4'b0101, 4'b0000, 1'b0);
        step(4'b1010, 4'b0010, 1'b0);
        step(4'b0110, 4'b0000, 1'b0);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);

        random_run(500);

        // Reset in the middle of a long falling-edge pulse, enable high at release
        repeat (12) step(4'b0000, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        repeat (3)  step(4'b0000, 4'b0000, 1'b0);
        step(4'b1111, 4'b0000, 1'b0);
        assert_reset();
        step(4'b1111, 4'b0000, 1'b1);
        repeat (3)  step(4'b1111, 4'b0000, 1'b0);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);

        random_run(200);
        repeat (12) step(4'b0000, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue drain: got %0d pending want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
